// File: rtl/bitrev_pkg.sv
// Shared types and helpers for the bit-reversed address sequencer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package bitrev_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of pairs one sweep emits for a given address width.
    function automatic int pair_count(input int addr_w);
`ifdef BITREV_SWAP_ONLY_EN
        return ((1 << addr_w) - (1 << ((addr_w + 1) / 2))) / 2;
`else
        return 1 << addr_w;
`endif
    endfunction

endpackage

// File: rtl/reverse_vector.sv
// Combinational bit-order reversal of a WIDTH-bit vector.
// Latency: 0 cycles (pure wiring).
// Backpressure: none, no storage.
module reverse_vector #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] in_vec,
    output logic [WIDTH-1:0] out_vec
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign out_vec[i] = in_vec[WIDTH-1-i];
    end

endmodule

// File: rtl/bitrev_addr_sequencer.sv
// Sweeps an index 0..2^ADDR_W-1 and emits (index, bit-reversed index) pairs; BITREV_SWAP_ONLY_EN keeps only a<b pairs.
// Latency: first pair valid one cycle after start; done pulses one cycle after the last pair.
// Backpressure: valid/ready; a stalled pair holds addr_a/addr_b/out_valid stable until accepted.
module bitrev_addr_sequencer
    import bitrev_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic              abort,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] rev_cnt;
    logic              emit;
    logic              advance;

    reverse_vector #(.WIDTH(ADDR_W)) u_rev (
        .in_vec  (cnt_q),
        .out_vec (rev_cnt)
    );

`ifdef BITREV_SWAP_ONLY_EN
    // Self-mapped and already-swapped indices are walked past without a handshake.
    assign emit = (cnt_q < rev_cnt);
`else
    assign emit = 1'b1;
`endif

    assign out_valid = (state_q == RUN) && emit;
    assign advance   = (state_q == RUN) && (emit ? out_ready : 1'b1);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end
                end
                RUN: begin
                    if (advance) begin
                        if (cnt_q == LAST_IDX) begin
                            state_d = DONE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign addr_a = cnt_q;
    assign addr_b = rev_cnt;
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);

endmodule
